// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared exception codes, controller states and stage indices
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        EXP_NONE     = 3'd0,
        EXP_EXT_INT  = 3'd1,
        EXP_UNDEF    = 3'd2,
        EXP_OVF      = 3'd3,
        EXP_MISALIGN = 3'd4,
        EXP_TRAP     = 3'd5,
        EXP_ILL_ERET = 3'd6
    } exp_code_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } ctrl_state_t;

    // Bit positions of each stage inside the 4-bit stall/flush vectors
    localparam int STG_IF  = 3;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 0;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - stall/bubble generation for bus-busy and load-use hazards
module pipe_ctrl_hazard
    import cpu_ctrl_pkg::*;
(
    input  logic       if_busy,
    input  logic       mem_busy,
    input  logic       ld_hazard,
    output logic       busy,
    output logic [3:0] stall,
    output logic [3:0] flush
);

    assign busy = if_busy | mem_busy;

    // Load-use: hold IF/ID and inject a bubble into EX so the load can reach MEM
    always_comb begin
        stall = 4'b0000;
        flush = 4'b0000;
        if (busy) begin
            stall = 4'b1111;
        end else if (ld_hazard) begin
            stall[STG_IF] = 1'b1;
            stall[STG_ID] = 1'b1;
            flush[STG_EX] = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline controller: hazards, exceptions, ERET, RUN/HANDLER/HALT; irq via PIPE_CTRL_EXT_IRQ_EN
module pipe_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 30,
    parameter logic [ADDR_W-1:0] EXP_VECTOR = 30'h0000_0040
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_CTRL_EXT_IRQ_EN
    input  logic              irq,
`endif
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [2:0]        mem_exp_code,
    input  logic              mem_eret,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] epc,
    output logic [2:0]        exp_cause,
    output logic              halted
);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    exp_code_t         cause_q, cause_d;

    logic       busy;
    logic [3:0] haz_stall, haz_flush;
    logic [3:0] stall, flush;
    logic       ev_exc, ev_irq, ev_eret, take_exc;
    exp_code_t  exc_code;

    pipe_ctrl_hazard u_hazard (
        .if_busy   (if_busy),
        .mem_busy  (mem_busy),
        .ld_hazard (ld_hazard),
        .busy      (busy),
        .stall     (haz_stall),
        .flush     (haz_flush)
    );

    // Events are only sampled from a valid MEM insn while the buses are free
    always_comb begin
        ev_exc  = mem_en && !busy && (exp_code_t'(mem_exp_code) != EXP_NONE);
`ifdef PIPE_CTRL_EXT_IRQ_EN
        ev_irq  = mem_en && !busy && irq && (state_q == RUN);
`else
        ev_irq  = 1'b0;
`endif
        ev_eret = mem_en && !busy && mem_eret;
        // ERET outside a handler is itself illegal and takes the exception path
        take_exc = ev_exc || ev_irq || (ev_eret && state_q == RUN);
        if (ev_exc)
            exc_code = exp_code_t'(mem_exp_code);
        else if (ev_irq)
            exc_code = EXP_EXT_INT;
        else
            exc_code = EXP_ILL_ERET;
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        stall   = haz_stall;
        flush   = haz_flush;
        new_pc  = EXP_VECTOR;
        if (rst) begin
            stall = 4'b0000;
            flush = 4'b0000;
        end else begin
            case (state_q)
                RUN, HANDLER: begin
                    if (take_exc) begin
                        stall = 4'b0000;
                        flush = 4'b1111;
                        if (state_q == RUN) begin
                            epc_d   = mem_pc;
                            cause_d = exc_code;
                            state_d = HANDLER;
                        end else begin
                            state_d = HALT;
                        end
                    end else if (ev_eret) begin
                        stall   = 4'b0000;
                        flush   = 4'b1111;
                        new_pc  = epc_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    stall = 4'b1111;
                    flush = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            epc_q   <= '0;
            cause_q <= EXP_NONE;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign if_stall  = stall[STG_IF];
    assign id_stall  = stall[STG_ID];
    assign ex_stall  = stall[STG_EX];
    assign mem_stall = stall[STG_MEM];
    assign if_flush  = flush[STG_IF];
    assign id_flush  = flush[STG_ID];
    assign ex_flush  = flush[STG_EX];
    assign mem_flush = flush[STG_MEM];
    assign epc       = epc_q;
    assign exp_cause = cause_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irq = 1'b0;
    logic        if_busy = 1'b0, mem_busy = 1'b0, ld_hazard = 1'b0;
    logic        mem_en = 1'b0, mem_eret = 1'b0;
    logic [29:0] mem_pc = '0;
    logic [2:0]  mem_exp_code = 3'd0;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc, epc;
    logic [2:0]  exp_cause;
    logic        halted;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic        chk_pc;
        logic [29:0] pc;
        logic [29:0] epc;
        logic [2:0]  cause;
        logic        halt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PIPE_CTRL_EXT_IRQ_EN
        .irq          (irq),
`endif
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .ld_hazard    (ld_hazard),
        .mem_en       (mem_en),
        .mem_pc       (mem_pc),
        .mem_exp_code (mem_exp_code),
        .mem_eret     (mem_eret),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .mem_stall    (mem_stall),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .ex_flush     (ex_flush),
        .mem_flush    (mem_flush),
        .new_pc       (new_pc),
        .epc          (epc),
        .exp_cause    (exp_cause),
        .halted       (halted)
    );

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic set_in(input logic ifb, input logic memb, input logic ldh, input logic en,
                          input logic [29:0] pc, input logic [2:0] code, input logic eret);
        if_busy = ifb; mem_busy = memb; ld_hazard = ldh;
        mem_en = en; mem_pc = pc; mem_exp_code = code; mem_eret = eret;
    endtask

    task automatic push(input string tag, input logic [3:0] st, input logic [3:0] fl, input logic chk_pc,
                        input logic [29:0] pc, input logic [29:0] e_epc, input logic [2:0] e_cause,
                        input logic e_halt);
        exp_t e;
        e.tag = tag; e.stall = st; e.flush = fl; e.chk_pc = chk_pc; e.pc = pc;
        e.epc = e_epc; e.cause = e_cause; e.halt = e_halt;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "stall", {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, e.stall});
        cmp(e.tag, "flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, e.flush});
        if (e.chk_pc) cmp(e.tag, "new_pc", {2'd0, new_pc}, {2'd0, e.pc});
        cmp(e.tag, "epc", {2'd0, epc}, {2'd0, e.epc});
        cmp(e.tag, "cause", {29'd0, exp_cause}, {29'd0, e.cause});
        cmp(e.tag, "halted", {31'd0, halted}, {31'd0, e.halt});
    endtask

    // Inputs are already driven just after a negedge; sample mid low-phase, then advance a cycle
    task automatic step(input string tag, input logic [3:0] st, input logic [3:0] fl, input logic chk_pc,
                        input logic [29:0] pc, input logic [29:0] e_epc, input logic [2:0] e_cause,
                        input logic e_halt);
        push(tag, st, fl, chk_pc, pc, e_epc, e_cause, e_halt);
        #2;
        check_out();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step("reset", 4'h0, 4'h0, 1'b1, 30'h40, 30'h0, 3'd0, 1'b0);
        rst = 1'b0;
        step("idle", 4'h0, 4'h0, 1'b0, 30'h0, 30'h0, 3'd0, 1'b0);

        set_in(0, 0, 1, 0, 30'h0, 3'd0, 0);
        step("ld_use", 4'b1100, 4'b0010, 1'b0, 30'h0, 30'h0, 3'd0, 1'b0);
        set_in(0, 0, 0, 0, 30'h0, 3'd0, 0);
        step("ld_clear", 4'h0, 4'h0, 1'b0, 30'h0, 30'h0, 3'd0, 1'b0);

        set_in(0, 0, 1, 1, 30'h100, 3'd3, 0);
        step("exc_ovf", 4'h0, 4'hF, 1'b1, 30'h40, 30'h0, 3'd0, 1'b0);
        set_in(0, 0, 0, 0, 30'h0, 3'd0, 0);
        step("handler", 4'h0, 4'h0, 1'b0, 30'h0, 30'h100, 3'd3, 1'b0);

        set_in(0, 1, 0, 1, 30'h104, 3'd0, 1);
        step("eret_membusy", 4'hF, 4'h0, 1'b0, 30'h0, 30'h100, 3'd3, 1'b0);
        set_in(1, 0, 0, 1, 30'h104, 3'd0, 1);
        step("eret_ifbusy", 4'hF, 4'h0, 1'b0, 30'h0, 30'h100, 3'd3, 1'b0);
        set_in(0, 0, 0, 1, 30'h104, 3'd0, 1);
        step("eret", 4'h0, 4'hF, 1'b1, 30'h100, 30'h100, 3'd3, 1'b0);
        set_in(0, 0, 1, 0, 30'h0, 3'd0, 0);
        step("back_run", 4'b1100, 4'b0010, 1'b0, 30'h0, 30'h100, 3'd3, 1'b0);

        set_in(0, 0, 0, 1, 30'h200, 3'd0, 1);
        step("eret_in_run", 4'h0, 4'hF, 1'b1, 30'h40, 30'h100, 3'd3, 1'b0);
        set_in(0, 0, 0, 0, 30'h201, 3'd2, 1);
        step("mem_en_off", 4'h0, 4'h0, 1'b0, 30'h0, 30'h200, 3'd6, 1'b0);

        set_in(0, 0, 0, 1, 30'h300, 3'd2, 0);
        step("double_fault", 4'h0, 4'hF, 1'b1, 30'h40, 30'h200, 3'd6, 1'b0);
        for (int i = 0; i < 22; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   30'($urandom), 3'($urandom_range(0, 6)), 1'($urandom));
            irq = 1'($urandom);
            step("halt", 4'hF, 4'h0, 1'b0, 30'h0, 30'h200, 3'd6, 1'b1);
        end
        irq = 1'b0;

        set_in(0, 0, 0, 1, 30'h50, 3'd5, 0);
        rst = 1'b1;
        step("rst_from_halt", 4'h0, 4'h0, 1'b1, 30'h40, 30'h0, 3'd0, 1'b0);
        rst = 1'b0;
        step("trap", 4'h0, 4'hF, 1'b1, 30'h40, 30'h0, 3'd0, 1'b0);
        set_in(0, 0, 0, 1, 30'h60, 3'd4, 0);
        #2;
        rst = 1'b1;
        step("rst_mid_flush", 4'h0, 4'h0, 1'b0, 30'h0, 30'h0, 3'd0, 1'b0);
        set_in(0, 0, 0, 0, 30'h0, 3'd0, 0);
        rst = 1'b0;
        step("post_rst", 4'h0, 4'h0, 1'b0, 30'h0, 30'h0, 3'd0, 1'b0);

`ifdef PIPE_CTRL_EXT_IRQ_EN
        irq = 1'b1;
        set_in(0, 0, 0, 1, 30'h20, 3'd0, 0);
        step("irq_run", 4'h0, 4'hF, 1'b1, 30'h40, 30'h0, 3'd0, 1'b0);
        set_in(0, 0, 0, 1, 30'h24, 3'd0, 0);
        step("irq_masked", 4'h0, 4'h0, 1'b0, 30'h0, 30'h20, 3'd1, 1'b0);
        set_in(0, 0, 0, 1, 30'h28, 3'd0, 1);
        step("irq_eret", 4'h0, 4'hF, 1'b1, 30'h20, 30'h20, 3'd1, 1'b0);
        set_in(0, 0, 0, 1, 30'h30, 3'd5, 0);
        step("irq_trap", 4'h0, 4'hF, 1'b1, 30'h40, 30'h20, 3'd1, 1'b0);
        irq = 1'b0;
        set_in(0, 0, 0, 0, 30'h0, 3'd0, 0);
        step("irq_trap_cause", 4'h0, 4'h0, 1'b0, 30'h0, 30'h30, 3'd5, 1'b0);
`endif

        tests++;
        assert (sb.size() == 0) else begin
            failed++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
